// File: rtl/mano_pkg.sv
// Shared constants for the basic-computer timing and control slice.
package mano_pkg;

    localparam int unsigned SC_WIDTH = 3;
    localparam int unsigned T_W      = 1 << SC_WIDTH;
    localparam int unsigned WORD_W   = 16;
    localparam int unsigned D_W      = 8;

    // Opcode values of IR[14:12]
    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_LDA   = 3'd2;
    localparam logic [2:0] OP_STA   = 3'd3;
    localparam logic [2:0] OP_BUN   = 3'd4;
    localparam logic [2:0] OP_BSA   = 3'd5;
    localparam logic [2:0] OP_ISZ   = 3'd6;
    localparam logic [2:0] OP_REGIO = 3'd7;

    // Register-reference bit indices
    localparam int unsigned RR_CLA = 11;
    localparam int unsigned RR_CLE = 10;
    localparam int unsigned RR_CMA = 9;
    localparam int unsigned RR_CME = 8;
    localparam int unsigned RR_CIR = 7;
    localparam int unsigned RR_CIL = 6;
    localparam int unsigned RR_INC = 5;
    localparam int unsigned RR_SPA = 4;
    localparam int unsigned RR_SNA = 3;
    localparam int unsigned RR_SZA = 2;
    localparam int unsigned RR_SZE = 1;
    localparam int unsigned RR_HLT = 0;

    // I/O bit indices
    localparam int unsigned IO_INP = 11;
    localparam int unsigned IO_OUT = 10;
    localparam int unsigned IO_SKI = 9;
    localparam int unsigned IO_SKO = 8;
    localparam int unsigned IO_ION = 7;
    localparam int unsigned IO_IOF = 6;

    // 3-to-8 one-hot decode
    function automatic logic [D_W-1:0] onehot8(input logic [2:0] sel);
        onehot8 = D_W'(1) << sel;
    endfunction

endpackage

// File: rtl/mano_timing_control_if.sv
// Control/bus bundle between the timing sequencer and the datapath.
interface mano_timing_control_if;
    import mano_pkg::*;

    logic              start;
    logic [WORD_W-1:0] bus_in;
    logic              fgi;
    logic              fgo;
    logic [T_W-1:0]    T;
    logic [D_W-1:0]    D;
    logic [WORD_W-1:0] B;
    logic              I;
    logic              run;
    logic              ar_from_pc;
    logic              pc_inr;
    logic              ir_ld;
    logic              ar_from_ir;
    logic              ar_from_mem;
    logic              sc_clr;
    logic              r_int;

    modport master (
        output start, bus_in, fgi, fgo,
        input  T, D, B, I, run, ar_from_pc, pc_inr, ir_ld,
               ar_from_ir, ar_from_mem, sc_clr, r_int
    );

    modport slave (
        input  start, bus_in, fgi, fgo,
        output T, D, B, I, run, ar_from_pc, pc_inr, ir_ld,
               ar_from_ir, ar_from_mem, sc_clr, r_int
    );

endinterface

// File: rtl/mano_seq_counter.sv
// Sequence counter SC with hold/clear/increment and the one-hot T decoder.
module mano_seq_counter
    import mano_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    output logic [T_W-1:0]      t
);

    logic [SC_WIDTH-1:0] sc;

    // SC stays at 0 while halted, clears on end-of-instruction, else counts (wraps at 7)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc <= '0;
        end else if (!en || clr) begin
            sc <= '0;
        end else begin
            sc <= sc + SC_WIDTH'(1);
        end
    end

    // Timing signals only live while the machine runs
    always_comb begin
        t = '0;
        if (en) begin
            t = T_W'(1) << sc;
        end
    end

endmodule

// File: rtl/mano_timing_control.sv
// Timing-and-control sequencer: SC, IR, I and S flip-flops, fetch/decode strobes.
// Optional interrupt cycle (IEN, R) is built when MANO_INTERRUPT_EN is defined.
module mano_timing_control
    import mano_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mano_timing_control_if.slave  tc
);

    logic [WORD_W-1:0] ir;
    logic              ind;
    logic              s_ff;
    logic              r_ff;
    logic [T_W-1:0]    t;
    logic [D_W-1:0]    d;
    logic              hlt;
    logic              exec_clr;
    logic              sc_clr;
    logic              ar_from_ir;
    logic              ir_ld;

    mano_seq_counter u_sc (
        .clk (clk),
        .rst (rst),
        .en  (s_ff),
        .clr (sc_clr),
        .t   (t)
    );

    // Decode, end-of-instruction and fetch/decode strobes
    always_comb begin
        d        = onehot8(ir[14:12]);
        hlt      = d[OP_REGIO] & ~ind & t[3] & ir[RR_HLT];
        exec_clr = ((d[OP_AND] | d[OP_ADD] | d[OP_LDA]) & t[5])
                 | ((d[OP_STA] | d[OP_BUN]) & t[4])
                 | (d[OP_BSA] & t[5])
                 | (d[OP_ISZ] & t[6])
                 | (d[OP_REGIO] & t[3]);
        sc_clr     = exec_clr | (r_ff & t[2]) | hlt;
        ir_ld      = ~r_ff & t[1];
        ar_from_ir = ~r_ff & t[2];
    end

    // Start/stop flip-flop; HLT has priority over a coincident start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ff <= 1'b0;
        end else if (hlt) begin
            s_ff <= 1'b0;
        end else if (tc.start) begin
            s_ff <= 1'b1;
        end
    end

    // Instruction register loads from the bus at the end of T1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= '0;
        end else if (ir_ld) begin
            ir <= tc.bus_in;
        end
    end

    // Indirect bit captured at the end of T2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ind <= 1'b0;
        end else if (ar_from_ir) begin
            ind <= ir[WORD_W-1];
        end
    end

`ifdef MANO_INTERRUPT_EN
    logic ien;
    logic io_t3;
    logic r_set;

    // Interrupt request detection and I/O enable/disable decode
    always_comb begin
        io_t3 = d[OP_REGIO] & ind & t[3];
        r_set = ~t[0] & ~t[1] & ~t[2] & ien & (tc.fgi | tc.fgo) & s_ff;
    end

    // R flip-flop: set outside fetch, cleared at the end of the interrupt cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ff <= 1'b0;
        end else if (r_ff && t[2]) begin
            r_ff <= 1'b0;
        end else if (r_set) begin
            r_ff <= 1'b1;
        end
    end

    // Interrupt enable: IOF beats ION when both bits are set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ien <= 1'b0;
        end else if (r_ff && t[2]) begin
            ien <= 1'b0;
        end else if (io_t3 && ir[IO_IOF]) begin
            ien <= 1'b0;
        end else if (io_t3 && ir[IO_ION]) begin
            ien <= 1'b1;
        end
    end
`else
    logic unused_flags;

    // Without the interrupt cycle R never asserts and the flags are ignored
    always_comb begin
        r_ff         = 1'b0;
        unused_flags = tc.fgi ^ tc.fgo;
    end
`endif

    // Output drive
    always_comb begin
        tc.T           = t;
        tc.D           = d;
        tc.B           = ir;
        tc.I           = ind;
        tc.run         = s_ff;
        tc.ar_from_pc  = ~r_ff & t[0];
        tc.ir_ld       = ir_ld;
        tc.pc_inr      = (~r_ff & t[1]) | (r_ff & t[2]);
        tc.ar_from_ir  = ar_from_ir;
        tc.ar_from_mem = ~d[OP_REGIO] & ind & t[3];
        tc.sc_clr      = sc_clr;
        tc.r_int       = r_ff;
    end

endmodule
